// File: rtl/store_sequencer_if.sv
// Store sequencer bundle: control-side request, memory-side handshake, merge-unit select.
// Latency: wires only, no storage.
// Backpressure: memory stalls the sequencer by withholding mem_ack.
interface store_sequencer_if #(
  parameter int ADDR_W = 32
);
  // Request from the main control unit
  logic              start;
  logic [1:0]        store_type;
  logic [ADDR_W-1:0] addr;
  // Memory port
  logic              mem_ack;
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  // Datapath controls and status
  logic              mdr_load;
  logic [1:0]        SSControl;
  logic              busy;
  logic              done;
  logic              align_err;

  // Sequencer side
  modport slave (
    input  start, store_type, addr, mem_ack,
    output mem_req, mem_wr, mem_addr, mdr_load, SSControl, busy, done, align_err
  );

  // Control unit + memory side
  modport master (
    output start, store_type, addr, mem_ack,
    input  mem_req, mem_wr, mem_addr, mdr_load, SSControl, busy, done, align_err
  );
endinterface

// File: rtl/store_sequencer.sv
// Store sequencer: sw writes directly; sh/sb read-merge-write through the MDR and merge unit.
// Latency: word 3 cycles start-to-idle, sub-word 5 cycles, plus one per memory wait cycle.
// Backpressure: holds each memory request until mem_ack; start while busy is dropped.
// Optional STORE_ALIGN_CHECK_EN: misaligned sh/sw go to ERR and pulse align_err instead of accessing memory.
module store_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  store_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_MERGE  = 3'd2,
    S_WR_REQ = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_WORD = 2'b01;
  localparam logic [1:0] ST_HALF = 2'b10;

  state_e            state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              accept;
  logic              misalign;

  // A store is taken only from IDLE and only with a real store type
  always_comb begin
    accept = (state_q == S_IDLE) && bus.start && (bus.store_type != ST_NONE);
  end

  // Alignment rule: halfword needs addr[0]=0, word needs addr[1:0]=00; bytes always fit
  always_comb begin
    misalign = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
    if (bus.store_type == ST_HALF && bus.addr[0]) begin
      misalign = 1'b1;
    end
    if (bus.store_type == ST_WORD && bus.addr[1:0] != 2'b00) begin
      misalign = 1'b1;
    end
`endif
  end

  // State register; reset aborts any outstanding request immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched type/address stay frozen for the whole operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      type_q <= ST_NONE;
      addr_q <= '0;
    end else begin
      type_q <= type_d;
      addr_q <= addr_d;
    end
  end

  // Capture the request on acceptance only
  always_comb begin
    type_d = type_q;
    addr_d = addr_q;
    if (accept) begin
      type_d = bus.store_type;
      addr_d = bus.addr;
    end
  end

  // Next-state: word goes straight to write, sub-word reads the target word first
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign) begin
            state_d = S_ERR;
          end else if (bus.store_type == ST_WORD) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (bus.mem_ack) begin
          state_d = S_MERGE;
        end
      end
      S_MERGE: begin
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (bus.mem_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode from state; only mdr_load looks at mem_ack, so MDR grabs the read data on the ack edge
  always_comb begin
    bus.mem_req   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    bus.mem_wr    = (state_q == S_WR_REQ);
    bus.mem_addr  = addr_q & ~ADDR_W'(3);
    bus.mdr_load  = (state_q == S_RD_REQ) && bus.mem_ack;
    bus.SSControl = ST_NONE;
    if (state_q == S_MERGE || state_q == S_WR_REQ) begin
      bus.SSControl = type_q;
    end
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
`ifdef STORE_ALIGN_CHECK_EN
    bus.align_err = (state_q == S_ERR);
`else
    bus.align_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: directed stores, memory model with programmable ack delay,
// expected events queued at issue time and checked by an independent monitor.
module tb_store_sequencer;

  localparam int ADDR_W = 32;

  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_MRG  = 3;
  localparam int K_DONE = 4;
  localparam int K_ERR  = 5;
  localparam int K_MDR  = 6;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [1:0]  ss;
    logic        mdr;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   ack_dly;
  int   wcnt;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_addr;
  ev_t  exp_q[$];
  ev_t  obs;
  ev_t  expv;
  logic have;
  int   t0;

  store_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  store_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] a, input logic [1:0] ss, input logic mdr);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.ss = ss; e.mdr = mdr;
    exp_q.push_back(e);
  endtask

  // Drive a one-cycle start at the current negedge; returns at the negedge of cycle 1
  task automatic do_start(input logic [1:0] st, input logic [31:0] a);
    bus.start      = 1'b1;
    bus.store_type = st;
    bus.addr       = a;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.store_type = 2'b00;
    bus.addr       = '0;
  endtask

  // Memory model: acknowledges each request after ack_dly wait cycles
  always @(negedge clk) begin
    if (reset && bus.mem_req) begin
      if (wcnt == ack_dly) begin
        bus.mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt = wcnt + 1;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: turns observed DUT activity into events and checks them against the queue
  always @(negedge clk) begin
    #2;
    if (reset) begin
      have = 1'b1;
      obs.cyc  = cyc;
      obs.addr = 32'h0;
      obs.ss   = bus.SSControl;
      obs.mdr  = bus.mdr_load;
      if (bus.mem_req && bus.mem_ack) begin
        obs.kind = bus.mem_wr ? K_WR : K_RD;
        obs.addr = bus.mem_addr;
      end else if (!bus.mem_req && bus.SSControl != 2'b00) begin
        obs.kind = K_MRG;
      end else if (bus.done) begin
        obs.kind = K_DONE;
      end else if (bus.align_err) begin
        obs.kind = K_ERR;
      end else if (bus.mdr_load) begin
        obs.kind = K_MDR;
      end else begin
        have = 1'b0;
      end
      if (have) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d addr %0h ss %0d, expected none",
                   obs.kind, obs.cyc, obs.addr, obs.ss);
        end else begin
          expv = exp_q.pop_front();
          if (obs.kind != expv.kind || obs.cyc != expv.cyc || obs.addr !== expv.addr ||
              obs.ss !== expv.ss || obs.mdr !== expv.mdr) begin
            n_err++;
            $display("FAIL event: got kind %0d cyc %0d addr %0h ss %0d mdr %0d, expected kind %0d cyc %0d addr %0h ss %0d mdr %0d",
                     obs.kind, obs.cyc, obs.addr, obs.ss, obs.mdr,
                     expv.kind, expv.cyc, expv.addr, expv.ss, expv.mdr);
          end
        end
      end
      if (bus.mem_req) begin
        chk("mem_addr_hold", bus.mem_addr, exp_addr);
      end
    end
  end

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0; ack_dly = 0; wcnt = 0; exp_addr = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.store_type = 2'b00; bus.addr = '0; bus.mem_ack = 1'b0;
    #12;
    chk("rst_mem_req",   bus.mem_req,   0);
    chk("rst_mem_wr",    bus.mem_wr,    0);
    chk("rst_mdr_load",  bus.mdr_load,  0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_done",      bus.done,      0);
    chk("rst_align_err", bus.align_err, 0);
    chk("rst_ss",        bus.SSControl, 0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Word store at 0x100, immediate ack, then a back-to-back word in the IDLE after DONE
    ack_dly = 0; exp_addr = 32'h100; t0 = cyc;
    push(K_WR, t0 + 1, 32'h100, 2'b01, 1'b0);
    push(K_DONE, t0 + 2, 32'h0, 2'b00, 1'b0);
    do_start(2'b01, 32'h100);
    #1 chk("word_busy_c1", bus.busy, 1);
    @(negedge clk); @(negedge clk);
    #1 chk("word_busy_c3", bus.busy, 0);
    exp_addr = 32'h104; t0 = cyc;
    push(K_WR, t0 + 1, 32'h104, 2'b01, 1'b0);
    push(K_DONE, t0 + 2, 32'h0, 2'b00, 1'b0);
    do_start(2'b01, 32'h104);
    drain(5);

    // Byte store at 0x203, two wait cycles on each request
    ack_dly = 2; exp_addr = 32'h200; t0 = cyc;
    push(K_RD, t0 + 3, 32'h200, 2'b00, 1'b1);
    push(K_MRG, t0 + 4, 32'h0, 2'b11, 1'b0);
    push(K_WR, t0 + 7, 32'h200, 2'b11, 1'b0);
    push(K_DONE, t0 + 8, 32'h0, 2'b00, 1'b0);
    do_start(2'b11, 32'h203);
    drain(11);

    // Halfword at 0x402 with a second start during RD_REQ that must be dropped
    ack_dly = 1; exp_addr = 32'h400; t0 = cyc;
    push(K_RD, t0 + 2, 32'h400, 2'b00, 1'b1);
    push(K_MRG, t0 + 3, 32'h0, 2'b10, 1'b0);
    push(K_WR, t0 + 5, 32'h400, 2'b10, 1'b0);
    push(K_DONE, t0 + 6, 32'h0, 2'b00, 1'b0);
    do_start(2'b10, 32'h402);
    do_start(2'b01, 32'h500);
    drain(10);

    // Reset asserted mid WR_REQ, then a clean halfword sequence
    ack_dly = 3; exp_addr = 32'h10; t0 = cyc;
    push(K_RD, t0 + 4, 32'h10, 2'b00, 1'b1);
    push(K_MRG, t0 + 5, 32'h0, 2'b10, 1'b0);
    do_start(2'b10, 32'h12);
    repeat (6) @(negedge clk);
    #1 chk("pre_rst_wr_req", bus.mem_wr, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_req",   bus.mem_req,   0);
    chk("arst_mem_wr",    bus.mem_wr,    0);
    chk("arst_mdr_load",  bus.mdr_load,  0);
    chk("arst_busy",      bus.busy,      0);
    chk("arst_done",      bus.done,      0);
    chk("arst_align_err", bus.align_err, 0);
    chk("arst_ss",        bus.SSControl, 0);
    chk("arst_mem_addr",  bus.mem_addr,  0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    chk("rst_abort_queue", exp_q.size(), 0);
    @(negedge clk);
    ack_dly = 0; exp_addr = 32'h20; t0 = cyc;
    push(K_RD, t0 + 1, 32'h20, 2'b00, 1'b1);
    push(K_MRG, t0 + 2, 32'h0, 2'b10, 1'b0);
    push(K_WR, t0 + 3, 32'h20, 2'b10, 1'b0);
    push(K_DONE, t0 + 4, 32'h0, 2'b00, 1'b0);
    do_start(2'b10, 32'h20);
    drain(7);

    // Misaligned halfword at 0x301
    ack_dly = 0; exp_addr = 32'h300; t0 = cyc;
`ifdef STORE_ALIGN_CHECK_EN
    push(K_ERR, t0 + 1, 32'h0, 2'b00, 1'b0);
    do_start(2'b10, 32'h301);
    @(negedge clk);
    #1 chk("err_busy_c2", bus.busy, 0);
`else
    push(K_RD, t0 + 1, 32'h300, 2'b00, 1'b1);
    push(K_MRG, t0 + 2, 32'h0, 2'b10, 1'b0);
    push(K_WR, t0 + 3, 32'h300, 2'b10, 1'b0);
    push(K_DONE, t0 + 4, 32'h0, 2'b00, 1'b0);
    do_start(2'b10, 32'h301);
`endif
    drain(7);

    // store_type 00 is not a store
    do_start(2'b00, 32'h700);
    #1 chk("none_busy_c1", bus.busy, 0);
    @(negedge clk);
    #1 chk("none_busy_c2", bus.busy, 0);
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
